// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and the coordinate type used by the VGA sync stage.
package vga_timing_pkg;

   localparam int COORD_W = 10;
   typedef logic [COORD_W-1:0] coord_t;

   localparam int H_DISPLAY_DEF = 640;
   localparam int H_FRONT_DEF   = 16;
   localparam int H_SYNC_DEF    = 96;
   localparam int H_BACK_DEF    = 48;
   localparam int V_DISPLAY_DEF = 480;
   localparam int V_FRONT_DEF   = 10;
   localparam int V_SYNC_DEF    = 2;
   localparam int V_BACK_DEF    = 33;

   localparam int H_TOTAL_DEF      = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
   localparam int V_TOTAL_DEF      = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;
   localparam int H_SYNC_START_DEF = H_DISPLAY_DEF + H_FRONT_DEF;
   localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF - 1;
   localparam int V_SYNC_START_DEF = V_DISPLAY_DEF + V_FRONT_DEF;
   localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF - 1;

   function automatic coord_t to_coord(input int value);
      return coord_t'(value);
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: enabled wrap counter that resets to its last position, plus
// decode of the value it will hold after this edge (sync window, display region).
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int DISPLAY = H_DISPLAY_DEF,
   parameter int FRONT   = H_FRONT_DEF,
   parameter int SYNC    = H_SYNC_DEF,
   parameter int BACK    = H_BACK_DEF
) (
   input  logic   i_clk,
   input  logic   i_rst,
   input  logic   i_en,
   output coord_t o_count,
   output logic   o_wrap,
   output logic   o_next_in_sync,
   output logic   o_next_in_display
);

   localparam int     TOTAL        = DISPLAY + FRONT + SYNC + BACK;
   localparam coord_t C_LAST       = to_coord(TOTAL - 1);
   localparam coord_t C_DISPLAY    = to_coord(DISPLAY);
   localparam coord_t C_SYNC_START = to_coord(DISPLAY + FRONT);
   localparam coord_t C_SYNC_END   = to_coord(DISPLAY + FRONT + SYNC - 1);

   coord_t r_count;
   coord_t w_next;
   logic   w_at_last;

   assign w_at_last = (r_count == C_LAST);
   assign o_wrap    = i_en & w_at_last;

   always_comb begin
      w_next = r_count;
      if (i_en) begin
         w_next = w_at_last ? '0 : r_count + coord_t'(1);
      end
   end

   // Reset to the last position so the first enabled step lands on 0.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_count <= C_LAST;
      end else begin
         r_count <= w_next;
      end
   end

   assign o_count           = r_count;
   assign o_next_in_sync    = (w_next >= C_SYNC_START) && (w_next <= C_SYNC_END);
   assign o_next_in_display = (w_next < C_DISPLAY);

endmodule

// File: rtl/vga_sync.sv
// 640x480@60 VGA timing generator on the 50 MHz board clock with a divide-by-2 pixel enable.
// Define VGA_SYNC_DIRECT_CLK_EN when clock_50 is already the pixel clock (enable held high).
module vga_sync
   import vga_timing_pkg::*;
#(
   parameter int   H_DISPLAY   = H_DISPLAY_DEF,
   parameter int   H_FRONT     = H_FRONT_DEF,
   parameter int   H_SYNC      = H_SYNC_DEF,
   parameter int   H_BACK      = H_BACK_DEF,
   parameter int   V_DISPLAY   = V_DISPLAY_DEF,
   parameter int   V_FRONT     = V_FRONT_DEF,
   parameter int   V_SYNC      = V_SYNC_DEF,
   parameter int   V_BACK      = V_BACK_DEF,
   parameter logic SYNC_ACTIVE = 1'b0
) (
   input  logic               clock_50,
   input  logic               reset,
   output logic               pixel_tick,
   output logic [COORD_W-1:0] pixel_x,
   output logic [COORD_W-1:0] pixel_y,
   output logic               display_on,
   output logic               hsync,
   output logic               vsync,
   output logic               frame_start
);

   logic   r_tick;
   logic   w_update;
   logic   w_h_wrap;
   logic   w_v_wrap;
   logic   w_h_next_sync;
   logic   w_v_next_sync;
   logic   w_h_next_disp;
   logic   w_v_next_disp;
   coord_t w_h_count;
   coord_t w_v_count;
   logic   r_display_on;
   logic   r_hsync;
   logic   r_vsync;
   logic   r_frame_start;

`ifdef VGA_SYNC_DIRECT_CLK_EN
   always_ff @(posedge clock_50 or posedge reset) begin
      if (reset) begin
         r_tick <= 1'b0;
      end else begin
         r_tick <= 1'b1;
      end
   end

   assign w_update = 1'b1;
`else
   // Counters step on edges where the enable is currently high, so each
   // position is held for two clock_50 cycles.
   always_ff @(posedge clock_50 or posedge reset) begin
      if (reset) begin
         r_tick <= 1'b0;
      end else begin
         r_tick <= ~r_tick;
      end
   end

   assign w_update = r_tick;
`endif

   vga_axis_counter #(
      .DISPLAY (H_DISPLAY),
      .FRONT   (H_FRONT),
      .SYNC    (H_SYNC),
      .BACK    (H_BACK)
   ) u_h_axis (
      .i_clk             (clock_50),
      .i_rst             (reset),
      .i_en              (w_update),
      .o_count           (w_h_count),
      .o_wrap            (w_h_wrap),
      .o_next_in_sync    (w_h_next_sync),
      .o_next_in_display (w_h_next_disp)
   );

   vga_axis_counter #(
      .DISPLAY (V_DISPLAY),
      .FRONT   (V_FRONT),
      .SYNC    (V_SYNC),
      .BACK    (V_BACK)
   ) u_v_axis (
      .i_clk             (clock_50),
      .i_rst             (reset),
      .i_en              (w_h_wrap),
      .o_count           (w_v_count),
      .o_wrap            (w_v_wrap),
      .o_next_in_sync    (w_v_next_sync),
      .o_next_in_display (w_v_next_disp)
   );

   // A vertical wrap only happens together with a horizontal wrap, so it marks (0,0).
   always_ff @(posedge clock_50 or posedge reset) begin
      if (reset) begin
         r_display_on  <= 1'b0;
         r_hsync       <= ~SYNC_ACTIVE;
         r_vsync       <= ~SYNC_ACTIVE;
         r_frame_start <= 1'b0;
      end else if (w_update) begin
         r_display_on  <= w_h_next_disp & w_v_next_disp;
         r_hsync       <= w_h_next_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         r_vsync       <= w_v_next_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         r_frame_start <= w_v_wrap;
      end
   end

   assign pixel_tick  = r_tick;
   assign pixel_x     = w_h_count;
   assign pixel_y     = w_v_count;
   assign display_on  = r_display_on;
   assign hsync       = r_hsync;
   assign vsync       = r_vsync;
   assign frame_start = r_frame_start;

endmodule

// File: doc/vga_sync.md
Name: vga_sync

Overview:
Upstream timing stage for the VGA colour generator. Runs on the 50 MHz board clock and derives a 25 MHz pixel-rate enable. Produces 640x480@60 horizontal/vertical counters, hsync/vsync and display_on. Its pixel_x, pixel_y and display_on outputs feed the colour stage's inputs directly.

Parameters:
H_DISPLAY, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_DISPLAY, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_ACTIVE, 0, logic level of hsync/vsync when asserted (0 = active-low)

Ports:
clock_50  in  1  50 MHz system clock
reset  in  1  asynchronous, active-high reset
pixel_tick  out  1  pixel-rate enable, high every second clock_50 cycle
pixel_x  out  10  horizontal position, 0..H_TOTAL-1
pixel_y  out  10  vertical position, 0..V_TOTAL-1
display_on  out  1  high when pixel_x < H_DISPLAY and pixel_y < V_DISPLAY
hsync  out  1  horizontal sync to connector
vsync  out  1  vertical sync to connector
frame_start  out  1  high for the pixel period at position (0,0)

Behaviour:
- Interface: one clock (clock_50); reset is asynchronous, active-high.
- H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800). V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525). Both must fit in 10 bits.
- Reset values:
  - pixel_tick = 0
  - pixel_x = H_TOTAL-1 (799), pixel_y = V_TOTAL-1 (524)
  - display_on = 0, frame_start = 0
  - hsync = vsync = ~SYNC_ACTIVE
- Reset can assert at any time. It forces all reset values immediately, independent of clock_50.
- Divider: pixel_tick toggles on every clock_50 rising edge. Counter and output updates happen only on edges where pixel_tick == 1. The first update is on the second rising edge after reset release. Each position is then held for exactly 2 clock_50 cycles.
- Horizontal counter: increments on each update. At H_TOTAL-1 it wraps to 0 and the vertical counter advances.
- Vertical counter: increments only on horizontal wrap. At V_TOTAL-1 it wraps to 0 when the horizontal counter also wraps.
- Post-reset start: the first update moves (799,524) to (0,0), so the first frame starts cleanly.
- All outputs are registered and decoded from the next count values, so they change together with pixel_x/pixel_y. No combinational path from counters to pins.
- hsync = SYNC_ACTIVE for pixel_x in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1], i.e. 656..751.
- vsync = SYNC_ACTIVE for pixel_y in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1], i.e. 490..491. vsync transitions coincide with pixel_x == 0.
- display_on and frame_start follow the definitions in Ports. frame_start lasts 2 clock_50 cycles.
- Frame period: 800*525*2 = 840000 clock_50 cycles.

Optional Feature:
VGA_SYNC_DIRECT_CLK_EN
- Defined: clock_50 is treated as the pixel clock (e.g. driven from a PLL at 25.175 MHz). pixel_tick is held at 1 after reset, counters advance on every edge, and each position lasts 1 cycle.
- Undefined: divide-by-2 enable as described in Behaviour.

Decomposition:
- Package vga_timing_pkg holds:
  - 640x480@60 default timing constants
  - derived H_TOTAL/V_TOTAL and sync start/end constants
  - 10-bit coordinate width constant
- Sub-module vga_axis_counter: enabled wrap counter with sync-window decode and wrap pulse. Instantiated twice, horizontal (enable = pixel_tick) and vertical (enable = horizontal wrap).

Test Plan:
- Reset mid-frame at pixel_x=300, pixel_y=200 -> outputs go to 799/524, display_on=0, hsync=vsync=1 with no clock edge. After release, pixel_x=0, pixel_y=0, frame_start=1 on the second clock_50 edge.
- Run one line -> pixel_x steps 0..799, each value held 2 cycles. hsync low exactly for pixel_x 656..751 (192 clock_50 cycles). display_on low from pixel_x 640.
- Run one full frame -> vsync low for pixel_y 490..491 (3200 cycles). frame_start recurs after exactly 840000 cycles.
- Check boundaries (639,479) -> display_on=1. (640,479) and (0,480) -> display_on=0. (799,524) -> (0,0) on the next update.
- With VGA_SYNC_DIRECT_CLK_EN defined -> pixel_tick constant 1. Line length 800 cycles, frame 420000 cycles.
- With SYNC_ACTIVE=1 -> hsync/vsync polarity inverted, with the same windows and counts.
